// File: rtl/bin2bcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bin2bcd_pkg                                                      |
// | Brief   : Shared state encoding, ASCII constants and digit-count helper.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  // Decimal digits needed to show 2**w - 1.
  function automatic int min_digits(input int w);
    longint unsigned v;
    int              d;
    v = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    d = 1;
    for (int i = 0; i < 20; i++) begin
      if (v >= 64'd10) begin
        v = v / 64'd10;
        d = d + 1;
      end
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_add3_nibble.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bcd_add3_nibble                                                  |
// | Brief   : Combinational "add 3 if >= 5" correction for one BCD digit.      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module bcd_add3_nibble (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule
`default_nettype wire

// File: rtl/bin2bcd_ascii_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bin2bcd_ascii_seq                                                |
// | Brief   : Sequential shift-and-add-3 binary to BCD/ASCII converter.        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module bin2bcd_ascii_seq
  import bin2bcd_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NDIGITS   = 5,
  parameter int SIGNED_EN = 0,
  parameter int BLANK_LZ  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_signed,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NDIGITS*4-1:0]     out_bcd,
  output logic [(NDIGITS+1)*8-1:0] out_ascii,
  output logic                     out_neg,
  output logic                     busy
);

  localparam int                BW       = NDIGITS * 4;
  localparam int                CW       = $clog2(DATA_W + 1);
  localparam logic [CW-1:0]     CNT_LOAD = CW'(DATA_W);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

  if (DATA_W < 2) begin : g_bad_width
    $error("bin2bcd_ascii_seq: DATA_W must be at least 2");
  end
  if (NDIGITS < min_digits(DATA_W)) begin : g_bad_ndigits
    $error("bin2bcd_ascii_seq: NDIGITS too small for DATA_W");
  end

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_mag;
  logic [BW-1:0]     r_bcd;
  logic              r_neg;

  logic              w_neg;
  logic [DATA_W-1:0] w_mag_in;
  logic [BW-1:0]     w_adj;
  logic [BW-1:0]     w_next_bcd;
  logic [DATA_W-1:0] w_next_mag;
  logic              w_zero_above;

  assign w_neg    = (SIGNED_EN != 0) && in_signed && in_data[DATA_W-1];
  assign w_mag_in = w_neg ? (~in_data + DATA_ONE) : in_data;

  for (genvar i = 0; i < NDIGITS; i++) begin : g_add3
    bcd_add3_nibble u_add3 (
      .din  (r_bcd[i*4 +: 4]),
      .dout (w_adj[i*4 +: 4])
    );
  end

  // The corrected digits and the remaining magnitude shift as one register.
  assign {w_next_bcd, w_next_mag} = {w_adj, r_mag} << 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_mag     <= '0;
      r_bcd     <= '0;
      r_neg     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_bcd   <= '0;
      out_neg   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mag    <= w_mag_in;
            r_neg    <= w_neg;
            r_bcd    <= '0;
            r_cnt    <= CNT_LOAD;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            r_state  <= CONV;
          end
        end
        CONV: begin
          r_bcd <= w_next_bcd;
          r_mag <= w_next_mag;
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            out_bcd   <= w_next_bcd;
            out_neg   <= r_neg;
            out_valid <= 1'b1;
            r_state   <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  // Text view of the held result; scanned from the top digit to track leading zeros.
  always_comb begin
    out_ascii    = '0;
    w_zero_above = 1'b1;
    out_ascii[NDIGITS*8 +: 8] = out_neg ? ASCII_MINUS : ASCII_SPACE;
    for (int k = NDIGITS - 1; k >= 0; k--) begin
      w_zero_above = w_zero_above && (out_bcd[k*4 +: 4] == 4'd0);
      if ((BLANK_LZ != 0) && (k > 0) && w_zero_above) begin
        out_ascii[k*8 +: 8] = ASCII_SPACE;
      end else begin
        out_ascii[k*8 +: 8] = ASCII_ZERO + {4'd0, out_bcd[k*4 +: 4]};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_ascii_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_bin2bcd_ascii_seq                                             |
// | Brief   : Three configurations driven in lockstep against a decimal model. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_bin2bcd_ascii_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_signed = 1'b0;
  logic        out_ready = 1'b0;

  // a: 16b signed-capable, blanking; b: 8b/3 digits, blanking; c: 16b unsigned, no blanking
  logic        a_in_ready, a_out_valid, a_neg, a_busy;
  logic [19:0] a_bcd;
  logic [47:0] a_ascii;
  logic        b_in_ready, b_out_valid, b_neg, b_busy;
  logic [11:0] b_bcd;
  logic [31:0] b_ascii;
  logic        c_in_ready, c_out_valid, c_neg, c_busy;
  logic [19:0] c_bcd;
  logic [47:0] c_ascii;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bin2bcd_ascii_seq #(.DATA_W(16), .NDIGITS(5), .SIGNED_EN(1), .BLANK_LZ(1)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_signed(in_signed), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_bcd(a_bcd), .out_ascii(a_ascii),
    .out_neg(a_neg), .busy(a_busy));

  bin2bcd_ascii_seq #(.DATA_W(8), .NDIGITS(3), .SIGNED_EN(0), .BLANK_LZ(1)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data[7:0]), .in_signed(in_signed), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_bcd(b_bcd), .out_ascii(b_ascii),
    .out_neg(b_neg), .busy(b_busy));

  bin2bcd_ascii_seq #(.DATA_W(16), .NDIGITS(5), .SIGNED_EN(0), .BLANK_LZ(0)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data), .in_signed(in_signed), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_bcd(c_bcd), .out_ascii(c_ascii),
    .out_neg(c_neg), .busy(c_busy));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decimal reference: digits by repeated division, blanks beyond the significant length.
  function automatic void model(input int unsigned v, input int w, input int nd,
                                input bit sen, input bit blk, input bit sgn,
                                output logic [63:0] bcd, output logic [63:0] asc,
                                output bit neg);
    int unsigned m;
    int unsigned t;
    int          nsig;
    v   = v & ((32'd1 << w) - 1);
    neg = sen && sgn && (((v >> (w - 1)) & 1) == 1);
    m   = neg ? ((32'd1 << w) - v) : v;
    nsig = 1;
    t = m / 10;
    while (t != 0) begin
      nsig++;
      t = t / 10;
    end
    bcd = '0;
    asc = '0;
    for (int k = 0; k < nd; k++) begin
      bcd[k*4 +: 4] = 4'(m % 10);
      asc[k*8 +: 8] = (blk && k >= nsig) ? 8'h20 : 8'(8'h30 + (m % 10));
      m = m / 10;
    end
    asc[nd*8 +: 8] = neg ? 8'h2D : 8'h20;
  endfunction

  // One word through all three instances; hold_cyc cycles of backpressure before release.
  task automatic run(input logic [15:0] v, input bit sgn, input int hold_cyc);
    logic [63:0] ea_bcd, ea_asc, eb_bcd, eb_asc, ec_bcd, ec_asc;
    bit          ea_neg, eb_neg, ec_neg;
    int          lat;
    int          lat_b;
    model(v, 16, 5, 1'b1, 1'b1, sgn, ea_bcd, ea_asc, ea_neg);
    model(v, 8, 3, 1'b0, 1'b1, sgn, eb_bcd, eb_asc, eb_neg);
    model(v, 16, 5, 1'b0, 1'b0, sgn, ec_bcd, ec_asc, ec_neg);
    check("in_ready_idle", a_in_ready, 1);
    in_data   = v;
    in_signed = sgn;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("busy_conv", a_busy, 1);
    check("in_ready_conv", a_in_ready, 0);
    lat   = 0;
    lat_b = -1;
    while (!a_out_valid && lat < 40) begin
      if (b_out_valid && lat_b < 0) lat_b = lat;
      tick();
      lat++;
    end
    check("latency_16", lat, 16);
    check("latency_8", lat_b, 8);
    check("c_valid", c_out_valid, 1);
    check("a_bcd", a_bcd, ea_bcd);
    check("a_ascii", a_ascii, ea_asc);
    check("a_neg", a_neg, ea_neg);
    check("b_ascii", b_ascii, eb_asc);
    check("b_bcd", b_bcd, eb_bcd);
    check("c_ascii", c_ascii, ec_asc);
    check("c_neg", c_neg, ec_neg);
    for (int i = 0; i < hold_cyc; i++) begin
      in_valid = (i == 3);
      in_data  = 16'h1111;
      tick();
      check("hold_ascii", a_ascii, ea_asc);
      check("hold_bcd", a_bcd, ea_bcd);
      check("hold_valid", a_out_valid, 1);
      check("hold_in_ready", a_in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_valid", a_out_valid, 0);
    check("release_in_ready", a_in_ready, 1);
    check("release_busy", b_busy, 0);
    check("retain_ascii", a_ascii, ea_asc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int t_prev;
    int n_seen;
    tick();
    check("rst_in_ready", a_in_ready, 1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_bcd", a_bcd, 0);
    check("rst_neg", a_neg, 0);
    check("rst_busy", a_busy, 0);
    check("rst_ascii_blank", a_ascii, "     0");
    check("rst_ascii_noblank", c_ascii, " 00000");
    reset = 1'b0;
    tick();

    run(16'hFFFF, 1'b0, 0);
    check("lit_65535_bcd", a_bcd, 20'h65535);
    check("lit_65535", a_ascii, " 65535");
    run(16'h0000, 1'b0, 0);
    check("lit_zero_blank", a_ascii, "     0");
    check("lit_zero_noblank", c_ascii, " 00000");
    run(16'h8000, 1'b1, 0);
    check("lit_m32768", a_ascii, "-32768");
    check("lit_m32768_bcd", a_bcd, 20'h32768);
    check("lit_c_unsigned", c_ascii, " 32768");
    check("lit_c_neg", c_neg, 0);
    run(16'hFFFF, 1'b1, 0);
    check("lit_m1", a_ascii, "-    1");
    run(16'h7FFF, 1'b1, 10);
    check("lit_32767", a_ascii, " 32767");
    run(16'd255, 1'b0, 0);
    check("lit_255", b_ascii, " 255");
    run(16'd100, 1'b0, 0);
    check("lit_100", b_ascii, " 100");
    run(16'd7, 1'b0, 0);
    check("lit_7", b_ascii, "   7");

    // Abort a conversion with reset partway through.
    in_data  = 16'd4321;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    reset = 1'b1;
    #1;
    check("abort_valid", a_out_valid, 0);
    check("abort_in_ready", a_in_ready, 1);
    check("abort_busy", a_busy, 0);
    check("abort_ascii", a_ascii, "     0");
    tick();
    reset = 1'b0;
    tick();
    run(16'd1234, 1'b0, 0);
    check("lit_1234", a_ascii, "  1234");

    for (int i = 0; i < 30; i++) begin
      run(16'($urandom), 1'($urandom_range(0, 1)), (i % 7 == 0) ? 3 : 0);
    end

    // Streaming on the 8-bit instance: one result every DATA_W+2 cycles.
    do_reset();
    in_data   = 16'd200;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    t_prev = -1;
    n_seen = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      tick();
      if (b_out_valid) begin
        if (t_prev >= 0) check("stream_period", cyc - t_prev, 10);
        check("stream_ascii", b_ascii, " 200");
        t_prev = cyc;
        n_seen++;
      end
    end
    check("stream_count_min", (n_seen >= 5), 1);
    in_valid = 1'b0;
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
